// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, parity selectors and default sizes
// used by both the transmitter and the receiver.
package uart_pkg;

  localparam int DEF_DATA_WIDTH    = 8;
  localparam int DEF_PRESCALE_BITS = 5;
  localparam int DEF_TX_BITS       = 4;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

endpackage

// File: rtl/uart_tx_serializer.sv
// Frame datapath for the UART transmitter: latched byte and prescale, per-bit cycle
// counter (edge_cnt) and data-bit index (bit_cnt).
module uart_tx_serializer
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
  parameter int PRESCALE_BITS = DEF_PRESCALE_BITS,
  parameter int TX_BITS       = DEF_TX_BITS
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     load_i,
  input  logic [DATA_WIDTH-1:0]    data_i,
  input  logic [PRESCALE_BITS-1:0] prescale_i,
  input  logic                     count_en_i,
  input  logic                     shift_en_i,
  output logic                     bit_done_o,
  output logic                     data_done_o,
  output logic                     next_bit_o,
  output logic [DATA_WIDTH-1:0]    data_o
);

  logic [DATA_WIDTH-1:0]    data_q,     data_d;
  logic [PRESCALE_BITS-1:0] presc_q,    presc_d;
  logic [PRESCALE_BITS-1:0] edge_cnt_q, edge_cnt_d;
  logic [TX_BITS-1:0]       bit_cnt_q,  bit_cnt_d;
  logic [DATA_WIDTH-1:0]    data_sh;
  logic                     last_bit;

  assign bit_done_o  = (edge_cnt_q == presc_q - PRESCALE_BITS'(1));
  assign last_bit    = (bit_cnt_q == TX_BITS'(DATA_WIDTH - 1));
  assign data_done_o = bit_done_o && last_bit;
  assign data_o      = data_q;

  // Bit that will be on the line after this edge, so the top can register TX_OUT.
  assign data_sh    = data_q >> bit_cnt_d;
  assign next_bit_o = data_sh[0];

  // NOTE: every always_comb output gets a default first, otherwise untaken branches infer latches.
  always_comb begin
    data_d     = data_q;
    presc_d    = presc_q;
    edge_cnt_d = edge_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    if (load_i) begin
      data_d     = data_i;
      presc_d    = (prescale_i == '0) ? PRESCALE_BITS'(1) : prescale_i;
      edge_cnt_d = '0;
      bit_cnt_d  = '0;
    end else if (count_en_i) begin
      edge_cnt_d = bit_done_o ? '0 : edge_cnt_q + PRESCALE_BITS'(1);
      if (shift_en_i && bit_done_o) begin
        bit_cnt_d = last_bit ? '0 : bit_cnt_q + TX_BITS'(1);
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q     <= '0;
      presc_q    <= '0;
      edge_cnt_q <= '0;
      bit_cnt_q  <= '0;
    end else begin
      data_q     <= data_d;
      presc_q    <= presc_d;
      edge_cnt_q <= edge_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
    end
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start bit, DATA_WIDTH data bits LSB first, optional parity, one stop
// bit, each held Prescale clock cycles. TX_OUT and Busy are registered.
module uart_tx
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
  parameter int PRESCALE_BITS = DEF_PRESCALE_BITS,
  parameter int TX_BITS       = DEF_TX_BITS
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic [DATA_WIDTH-1:0]    P_DATA,
  input  logic                     Data_Valid,
  input  logic                     PAR_EN,
  input  logic                     PAR_TYP,
  input  logic [PRESCALE_BITS-1:0] Prescale,
  output logic                     TX_OUT,
  output logic                     Busy
);

  uart_state_e           state_q, state_d;
  logic                  tx_q, tx_d;
  logic                  busy_q, busy_d;
  logic                  par_en_q, par_en_d;
  logic                  par_typ_q, par_typ_d;
  logic                  load, count_en, shift_en;
  logic                  bit_done, data_done, next_bit, parity_bit;
  logic [DATA_WIDTH-1:0] data;

  uart_tx_serializer #(
    .DATA_WIDTH   (DATA_WIDTH),
    .PRESCALE_BITS(PRESCALE_BITS),
    .TX_BITS      (TX_BITS)
  ) u_serializer (
    .clk        (CLK),
    .rst_n      (RST),
    .load_i     (load),
    .data_i     (P_DATA),
    .prescale_i (Prescale),
    .count_en_i (count_en),
    .shift_en_i (shift_en),
    .bit_done_o (bit_done),
    .data_done_o(data_done),
    .next_bit_o (next_bit),
    .data_o     (data)
  );

  assign parity_bit = (par_typ_q == PAR_ODD) ? ~^data : ^data;

  always_comb begin
    state_d   = state_q;
    par_en_d  = par_en_q;
    par_typ_d = par_typ_q;
    load      = 1'b0;
    count_en  = (state_q != ST_IDLE);
    shift_en  = (state_q == ST_DATA);
    case (state_q)
      ST_IDLE: begin
        if (Data_Valid) begin
          load      = 1'b1;
          par_en_d  = PAR_EN;
          par_typ_d = PAR_TYP;
          state_d   = ST_START;
        end
      end
      ST_START:  if (bit_done)  state_d = ST_DATA;
      ST_DATA:   if (data_done) state_d = par_en_q ? ST_PARITY : ST_STOP;
      ST_PARITY: if (bit_done)  state_d = ST_STOP;
      ST_STOP:   if (bit_done)  state_d = ST_IDLE;
      default:                  state_d = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they change on the same edge as the FSM.
  always_comb begin
    busy_d = (state_d != ST_IDLE);
    case (state_d)
      ST_START:  tx_d = 1'b0;
      ST_DATA:   tx_d = next_bit;
      ST_PARITY: tx_d = parity_bit;
      default:   tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q   <= ST_IDLE;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
      par_en_q  <= 1'b0;
      par_typ_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
      par_en_q  <= par_en_d;
      par_typ_q <= par_typ_d;
    end
  end

  assign TX_OUT = tx_q;
  assign Busy   = busy_q;

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: directed frames from the test plan plus random frames,
// compared cycle by cycle against a frame model built from the byte and settings.
module tb_uart_tx;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic [7:0] P_DATA = '0;
  logic       Data_Valid = 1'b0;
  logic       PAR_EN = 1'b0;
  logic       PAR_TYP = 1'b0;
  logic [4:0] Prescale = 5'd1;
  logic       TX_OUT;
  logic       Busy;

  int errors = 0;
  int checks = 0;

  uart_tx dut (
    .CLK       (CLK),
    .RST       (RST),
    .P_DATA    (P_DATA),
    .Data_Valid(Data_Valid),
    .PAR_EN    (PAR_EN),
    .PAR_TYP   (PAR_TYP),
    .Prescale  (Prescale),
    .TX_OUT    (TX_OUT),
    .Busy      (Busy)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference frame: bit idx of the serial frame (0 = start, then data LSB first,
  // then parity making the total ones count even/odd, then stop).
  function automatic logic model_bit(input logic [7:0] d, input logic pe, input logic pt,
                                     input int idx);
    int ones;
    ones = $countones(d);
    if (idx == 0) return 1'b0;
    if (idx <= 8) return d[idx-1];
    if (idx == 9 && pe) return logic'((ones % 2) != 0) ^ pt;
    return 1'b1;
  endfunction

  // Checks the frame already accepted on the last posedge; called at the negedge after it.
  // With disturb set, a second request and new settings are applied at cycle 20.
  task automatic check_frame(input string tag, input logic [7:0] d, input logic pe,
                             input logic pt, input logic [4:0] ps, input bit disturb);
    int eff;
    int n;
    eff = (ps == 0) ? 1 : int'(ps);
    n   = (10 + int'(pe)) * eff;
    for (int c = 0; c < n; c++) begin
      check({tag, "_tx"},   32'(TX_OUT), 32'(model_bit(d, pe, pt, c / eff)));
      check({tag, "_busy"}, 32'(Busy),   32'd1);
      if (disturb && c == 20) begin
        Data_Valid = 1'b1;
        P_DATA     = 8'h3C;
        Prescale   = 5'd3;
        PAR_EN     = ~pe;
      end else if (disturb && c == 21) begin
        Data_Valid = 1'b0;
      end
      @(negedge CLK);
    end
  endtask

  task automatic send_frame(input string tag, input logic [7:0] d, input logic pe,
                            input logic pt, input logic [4:0] ps, input bit disturb);
    P_DATA = d; PAR_EN = pe; PAR_TYP = pt; Prescale = ps;
    Data_Valid = 1'b1;
    @(negedge CLK);
    Data_Valid = 1'b0;
    check_frame(tag, d, pe, pt, ps, disturb);
    check({tag, "_idle_tx"},   32'(TX_OUT), 32'd1);
    check({tag, "_idle_busy"}, 32'(Busy),   32'd0);
    @(negedge CLK);
    check({tag, "_idle2_tx"},   32'(TX_OUT), 32'd1);
    check({tag, "_idle2_busy"}, 32'(Busy),   32'd0);
  endtask

  initial begin
    #12;
    check("reset_tx",   32'(TX_OUT), 32'd1);
    check("reset_busy", 32'(Busy),   32'd0);
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    check("post_reset_tx",   32'(TX_OUT), 32'd1);
    check("post_reset_busy", 32'(Busy),   32'd0);

    send_frame("a5_even_p8", 8'hA5, 1'b1, 1'b0, 5'd8, 1'b0);
    send_frame("01_odd_p4",  8'h01, 1'b1, 1'b1, 5'd4, 1'b0);
    send_frame("03_odd_p4",  8'h03, 1'b1, 1'b1, 5'd4, 1'b0);
    send_frame("ff_p1",      8'hFF, 1'b0, 1'b0, 5'd1, 1'b0);
    send_frame("ff_p0",      8'hFF, 1'b0, 1'b0, 5'd0, 1'b0);
    send_frame("a5_disturb", 8'hA5, 1'b1, 1'b0, 5'd8, 1'b1);
    send_frame("max_presc",  8'h96, 1'b1, 1'b1, 5'd31, 1'b0);

    // Data_Valid held high: two frames separated by a single idle cycle.
    P_DATA = 8'h55; PAR_EN = 1'b0; PAR_TYP = 1'b0; Prescale = 5'd2;
    Data_Valid = 1'b1;
    @(negedge CLK);
    P_DATA = 8'hAA;
    check_frame("b2b_55", 8'h55, 1'b0, 1'b0, 5'd2, 1'b0);
    check("b2b_gap_tx",   32'(TX_OUT), 32'd1);
    check("b2b_gap_busy", 32'(Busy),   32'd0);
    @(negedge CLK);
    Data_Valid = 1'b0;
    check_frame("b2b_aa", 8'hAA, 1'b0, 1'b0, 5'd2, 1'b0);
    check("b2b_end_busy", 32'(Busy), 32'd0);
    @(negedge CLK);

    // Asynchronous reset in the middle of the data bits.
    P_DATA = 8'h00; PAR_EN = 1'b1; PAR_TYP = 1'b0; Prescale = 5'd4;
    Data_Valid = 1'b1;
    @(negedge CLK);
    Data_Valid = 1'b0;
    repeat (12) @(negedge CLK);
    check("pre_rst_busy", 32'(Busy),   32'd1);
    check("pre_rst_tx",   32'(TX_OUT), 32'd0);
    #2 RST = 1'b0;
    #1;
    check("async_rst_tx",   32'(TX_OUT), 32'd1);
    check("async_rst_busy", 32'(Busy),   32'd0);
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    send_frame("after_rst", 8'hC3, 1'b1, 1'b1, 5'd3, 1'b0);

    // Random frames against the model.
    for (int i = 0; i < 24; i++) begin
      logic [7:0] d;
      logic       pe, pt;
      logic [4:0] ps;
      d  = 8'($urandom_range(0, 255));
      pe = 1'($urandom_range(0, 1));
      pt = 1'($urandom_range(0, 1));
      ps = 5'($urandom_range(0, 9));
      send_frame($sformatf("rand%0d", i), d, pe, pt, ps, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
# uart_tx

UART transmitter, the transmit half of the UART block pair: accepts a parallel byte with a one-cycle valid strobe, then serialises it onto a single line as start bit, DATA_WIDTH data bits LSB first, optional parity bit and one stop bit. Each bit lasts Prescale clock cycles, so the transmitter shares the same clock and Prescale register as the receiver. Sits between the system-side data producer and the TX pad.

## Interface
- DATA_WIDTH, 8, data bits per frame
- PRESCALE_BITS, 5, width of Prescale and of the per-bit cycle counter
- TX_BITS, 4, width of the data-bit counter (must hold DATA_WIDTH)
- CLK  in  1  clock
- RST  in  1  reset; asynchronous, active-low
- P_DATA  in  DATA_WIDTH  byte to send, sampled only on acceptance
- Data_Valid  in  1  request strobe; accepted only when Busy=0
- PAR_EN  in  1  1 = insert parity bit
- PAR_TYP  in  1  0 = even, 1 = odd parity
- Prescale  in  PRESCALE_BITS  clock cycles per bit; legal 1..2^PRESCALE_BITS-1; 0 treated as 1
- TX_OUT  out  1  serial line, registered; idle high
- Busy  out  1  registered; high from acceptance to end of stop bit

## Operation
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE: TX_OUT=1, Busy=0. If Data_Valid=1, latch P_DATA, PAR_EN, PAR_TYP and Prescale into frame registers; go to START.
- START: TX_OUT=0 for Prescale cycles -> DATA.
- DATA: TX_OUT = latched data[bit_cnt], bit_cnt 0..DATA_WIDTH-1, each held Prescale cycles. After last bit -> PARITY if latched PAR_EN, else STOP.
- PARITY: TX_OUT = ^data (even) or ~^data (odd), computed from latched data; Prescale cycles -> STOP.
- STOP: TX_OUT=1 for Prescale cycles -> IDLE.
- edge_cnt counts 0..Prescale-1, wraps to 0 at each bit boundary; state/bit advance only when edge_cnt==Prescale-1.
- Input changes on P_DATA/PAR_EN/PAR_TYP/Prescale mid-frame have no effect on the current frame.
- Data_Valid while Busy=1 is ignored (not queued).
- Undefined state encoding -> IDLE.

## Timing
- Reset values: TX_OUT=1, Busy=0, state IDLE, counters 0, frame registers 0. Reset mid-frame aborts immediately (asynchronous); line returns high.
- Acceptance edge: the rising edge where state=IDLE and Data_Valid=1. After it, TX_OUT=0 and Busy=1 (zero-cycle gap, no extra latency).
- Frame length N = (2 + DATA_WIDTH + PAR_EN) x Prescale cycles; Busy high exactly N cycles.
- Busy falls on the same edge that ends STOP; TX_OUT stays 1. Earliest next acceptance is the following edge, so consecutive frames are separated by exactly one idle-high cycle when Data_Valid is held high.
- Data_Valid is level-sampled; holding it high across a frame produces one new frame per IDLE visit, using P_DATA at that edge.

## Structure
- Shared package uart_pkg (used by the receiver too): FSM state encoding constants, PAR_EVEN=0 / PAR_ODD=1, default DATA_WIDTH/PRESCALE_BITS/TX_BITS.
- One sub-module: uart_tx_serializer holding latched data, bit_cnt and edge_cnt, with load/shift-enable inputs and bit-done/data-done outputs; FSM, parity computation and output mux stay in uart_tx.

## Test plan
- P_DATA=0xA5, PAR_EN=1, PAR_TYP=0, Prescale=8 -> TX_OUT = 0,1,0,1,0,0,1,0,1,0,1, each bit 8 cycles; Busy high 88 cycles.
- P_DATA=0x01, PAR_EN=1, PAR_TYP=1, Prescale=4 -> parity bit 0; P_DATA=0x03 same settings -> parity bit 1; frames 44 cycles.
- P_DATA=0xFF, PAR_EN=0, Prescale=1 -> 0 then nine 1s, Busy high 10 cycles; Prescale=0 gives identical waveform.
- Data_Valid pulsed with 0x3C at cycle 20 of a 0xA5 frame -> ignored; 0xA5 frame unchanged, line idle afterwards; changing P_DATA/Prescale mid-frame likewise no effect.
- Data_Valid held high, P_DATA 0x55 then 0xAA, PAR_EN=0, Prescale=2 -> two 20-cycle frames separated by exactly one idle-high cycle with Busy=0.
- RST asserted mid-DATA -> TX_OUT=1 and Busy=0 immediately; after release, new Data_Valid sends a complete correct frame.
